cmp_share_sched: RTL

- Round-robin scheduler that time-shares one twobit_comparator instance among N_REQ requesters.
- Each requester presents a pair of 2-bit operands.
- The scheduler grants one requester at a time, latches that requester's operands, and drives them into the comparator. It then returns a registered greater/equal/less result tagged with the requester ID.
- Sits between the lab's operand sources (switch/counter blocks) and the shared comparator datapath.

---
 rtl/cmp_share_sched_pkg.sv | 13 +
 rtl/cmp_share_sched_twobit_comparator.sv | 17 +
 rtl/cmp_share_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cmp_share_sched_pkg.sv
// Shared definitions for the comparator-sharing scheduler: FSM state
// encoding and the requester ID width.
package cmp_share_sched_pkg;

   localparam int ID_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage : cmp_share_sched_pkg

// File: rtl/cmp_share_sched_twobit_comparator.sv
// Two-bit magnitude comparator: A = {a,b}, B = {c,d}.
// f1 = A > B, f2 = A == B, f3 = A < B. Purely combinational.
module twobit_comparator (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic f1,
   output logic f2,
   output logic f3
);

   assign f1 = (a & ~c) | (b & ~c & ~d) | (a & b & ~d);
   assign f2 = (a ~^ c) & (b ~^ d);
   assign f3 = (~a & c) | (~a & ~b & d) | (~b & c & d);

endmodule : twobit_comparator

// File: rtl/cmp_share_sched.sv
// Round-robin scheduler that time-shares one twobit_comparator among
// N_REQ requesters. IDLE arbitrates and latches the winner's operands,
// CMP drives them through the comparator, RESP presents the registered
// result for one cycle.
module cmp_share_sched
   import cmp_share_sched_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [2*N_REQ-1:0] op_a,
   input  logic [2*N_REQ-1:0] op_b,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               rsp_valid,
   output logic [ID_W-1:0]    rsp_id,
   output logic               rsp_gt,
   output logic               rsp_eq,
   output logic               rsp_lt
);

   state_e          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] id_q;
   logic [1:0]      op_a_q;
   logic [1:0]      op_b_q;

   logic              pick_valid;
   logic [ID_W-1:0]   pick_id;
   logic [1:0]        sel_a;
   logic [1:0]        sel_b;
   logic [N_REQ-1:0]  grant_nxt;
   logic              f1, f2, f3;

   // Round-robin pick: the requester with the smallest distance from ptr
   // (wrapping at N_REQ) wins; its operand slices and one-hot grant follow.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      int best_d;
      int d;
      pick_valid = 1'b0;
      pick_id    = '0;
      sel_a      = '0;
      sel_b      = '0;
      grant_nxt  = '0;
      best_d     = N_REQ;
      d          = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) begin
            d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N_REQ - int'(ptr));
            if (d < best_d) begin
               best_d     = d;
               pick_valid = 1'b1;
               pick_id    = ID_W'(i);
            end
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_id == ID_W'(i)) begin
            sel_a        = op_a[2*i +: 2];
            sel_b        = op_b[2*i +: 2];
            grant_nxt[i] = pick_valid;
         end
      end
   end

   // Shared comparator, fed only from the latched operands.
   twobit_comparator u_twobit_comparator (
      .a  (op_a_q[1]),
      .b  (op_a_q[0]),
      .c  (op_b_q[1]),
      .d  (op_b_q[0]),
      .f1 (f1),
      .f2 (f2),
      .f3 (f3)
   );

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         id_q      <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         grant     <= '0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_gt    <= 1'b0;
         rsp_eq    <= 1'b0;
         rsp_lt    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant  <= grant_nxt;
                  op_a_q <= sel_a;
                  op_b_q <= sel_b;
                  id_q   <= pick_id;
                  busy   <= 1'b1;
                  state  <= CMP;
               end
            end
            CMP: begin
               rsp_gt    <= f1;
               rsp_eq    <= f2;
               rsp_lt    <= f3;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               ptr       <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
               grant     <= '0;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               grant     <= '0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule : cmp_share_sched
